mul_issue_ctrl: RTL and testbench

- Controller for the 32x32 radix-4 Booth multiplier datapath: Booth encoder / 17-row partial-product generator, carry-save compressor tree and final carry-propagate adder.
- Arbitrates two requesters (port 0: integer pipe, port 1: address/MAC unit) round-robin.
- Owns the 3-stage pipeline valid/tag/control state and drives the datapath register enables.
- Returns the selected 32-bit half of the 64-bit product with the requester id and tag, under a valid/ready handshake with bubble collapsing.

---
 rtl/mul_issue_ctrl.sv | 135 +++++++++++++
 tb/tb_mul_issue_ctrl.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mul_issue_ctrl.sv
// Issue/pipeline controller for the 32x32 radix-4 Booth multiplier: round-robin
// arbitration of two requesters, S1-S3 valid/tag tracking and datapath enables.
module mul_issue_ctrl #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [XLEN-1:0]  req0_a,
    input  logic [XLEN-1:0]  req0_b,
    input  logic             req0_sa,
    input  logic             req0_sb,
    input  logic             req0_hi,
    input  logic [TAG_W-1:0] req0_tag,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [XLEN-1:0]  req1_a,
    input  logic [XLEN-1:0]  req1_b,
    input  logic             req1_sa,
    input  logic             req1_sb,
    input  logic             req1_hi,
    input  logic [TAG_W-1:0] req1_tag,
    output logic [XLEN-1:0]  dp_a,
    output logic [XLEN-1:0]  dp_b,
    output logic             dp_sa,
    output logic             dp_sb,
    output logic             dp_en_s2,
    output logic             dp_en_s3,
    input  logic [63:0]      dp_prod,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [XLEN-1:0]  resp_data,
    output logic             resp_id,
    output logic [TAG_W-1:0] resp_tag,
    output logic [1:0]       inflight
);

    logic             vld_p0, vld_p1, vld_p2;
    logic             rr;
    logic [XLEN-1:0]  a_p0, b_p0;
    logic             sa_p0, sb_p0, hi_p0, id_p0;
    logic [TAG_W-1:0] tag_p0;
    logic             hi_p1, id_p1;
    logic [TAG_W-1:0] tag_p1;
    logic             hi_p2, id_p2;
    logic [TAG_W-1:0] tag_p2;

    logic adv3, free3, free2, free1;
    logic grant0, grant1, acc0, acc1, accept;

    // Advance chain resolved from the output end backwards so a stall only
    // freezes stages whose successor is still occupied.
    always_comb begin
        adv3     = vld_p2 & resp_ready;
        free3    = !vld_p2 | adv3;
        dp_en_s3 = vld_p1 & free3;
        free2    = !vld_p1 | dp_en_s3;
        dp_en_s2 = vld_p0 & free2;
        free1    = !vld_p0 | dp_en_s2;
    end

    assign grant0     = req0_valid & (!req1_valid | !rr);
    assign grant1     = req1_valid & (!req0_valid | rr);
    assign req0_ready = free1 & !flush & !rst & grant0;
    assign req1_ready = free1 & !flush & !rst & grant1;
    assign acc0       = req0_ready & req0_valid;
    assign acc1       = req1_ready & req1_valid;
    assign accept     = acc0 | acc1;

    // S1: accept point; operand and control registers feed the Booth/PP stage
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p0 <= 1'b0;
            vld_p1 <= 1'b0;
            vld_p2 <= 1'b0;
            rr     <= 1'b0;
            a_p0   <= '0;
            b_p0   <= '0;
            sa_p0  <= 1'b0;
            sb_p0  <= 1'b0;
            hi_p0  <= 1'b0;
            id_p0  <= 1'b0;
            tag_p0 <= '0;
        end else begin
            if (flush) begin
                vld_p0 <= 1'b0;
                vld_p1 <= 1'b0;
                vld_p2 <= 1'b0;
            end else begin
                vld_p0 <= accept | (vld_p0 & !dp_en_s2);
                vld_p1 <= dp_en_s2 | (vld_p1 & !dp_en_s3);
                vld_p2 <= dp_en_s3 | (vld_p2 & !adv3);
            end
            if (accept) begin
                rr     <= acc0;
                a_p0   <= acc1 ? req1_a   : req0_a;
                b_p0   <= acc1 ? req1_b   : req0_b;
                sa_p0  <= acc1 ? req1_sa  : req0_sa;
                sb_p0  <= acc1 ? req1_sb  : req0_sb;
                hi_p0  <= acc1 ? req1_hi  : req0_hi;
                tag_p0 <= acc1 ? req1_tag : req0_tag;
                id_p0  <= acc1;
            end
        end
    end

    // S2 / S3: response metadata rides alongside the compressor and adder registers
    always_ff @(posedge clk) begin
        if (dp_en_s2) begin
            hi_p1  <= hi_p0;
            id_p1  <= id_p0;
            tag_p1 <= tag_p0;
        end
        if (dp_en_s3) begin
            hi_p2  <= hi_p1;
            id_p2  <= id_p1;
            tag_p2 <= tag_p1;
        end
    end

    assign dp_a  = a_p0;
    assign dp_b  = b_p0;
    assign dp_sa = sa_p0;
    assign dp_sb = sb_p0;

    assign resp_valid = vld_p2;
    assign resp_data  = hi_p2 ? dp_prod[63:32] : dp_prod[31:0];
    assign resp_id    = id_p2;
    assign resp_tag   = tag_p2;
    assign inflight   = {1'b0, vld_p0} + {1'b0, vld_p1} + {1'b0, vld_p2};

endmodule

// File: tb/tb_mul_issue_ctrl.sv
// Directed bench for mul_issue_ctrl with a two-register behavioural multiplier
// standing in for the Booth/compressor/adder datapath.
module tb_mul_issue_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush;
    logic        req0_valid, req0_ready, req0_sa, req0_sb, req0_hi;
    logic [31:0] req0_a, req0_b;
    logic [3:0]  req0_tag;
    logic        req1_valid, req1_ready, req1_sa, req1_sb, req1_hi;
    logic [31:0] req1_a, req1_b;
    logic [3:0]  req1_tag;
    logic [31:0] dp_a, dp_b;
    logic        dp_sa, dp_sb, dp_en_s2, dp_en_s3;
    logic [63:0] dp_prod, s2_prod;
    logic        resp_valid, resp_ready, resp_id;
    logic [31:0] resp_data;
    logic [3:0]  resp_tag;
    logic [1:0]  inflight;

    int n_vec = 0;
    int n_err = 0;

    mul_issue_ctrl #(.XLEN(32), .TAG_W(4)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
        .req0_sa(req0_sa), .req0_sb(req0_sb), .req0_hi(req0_hi), .req0_tag(req0_tag),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
        .req1_sa(req1_sa), .req1_sb(req1_sb), .req1_hi(req1_hi), .req1_tag(req1_tag),
        .dp_a(dp_a), .dp_b(dp_b), .dp_sa(dp_sa), .dp_sb(dp_sb),
        .dp_en_s2(dp_en_s2), .dp_en_s3(dp_en_s3), .dp_prod(dp_prod),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
        .resp_id(resp_id), .resp_tag(resp_tag), .inflight(inflight)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] mul64(input logic [31:0] a, input logic [31:0] b,
                                          input logic sa, input logic sb);
        logic [63:0] ea, eb;
        ea = sa ? {{32{a[31]}}, a} : {32'b0, a};
        eb = sb ? {{32{b[31]}}, b} : {32'b0, b};
        return ea * eb;
    endfunction

    // Datapath stand-in: S2 holds the raw product, S3 is the product register.
    always @(posedge clk) begin
        if (dp_en_s2) s2_prod <= mul64(dp_a, dp_b, dp_sa, dp_sb);
        if (dp_en_s3) dp_prod <= s2_prod;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic clr();
        req0_valid = 0; req0_a = 0; req0_b = 0; req0_sa = 0; req0_sb = 0; req0_hi = 0; req0_tag = 0;
        req1_valid = 0; req1_a = 0; req1_b = 0; req1_sa = 0; req1_sb = 0; req1_hi = 0; req1_tag = 0;
    endtask

    task automatic drv(input bit p, input logic [31:0] a, input logic [31:0] b,
                       input bit sa, input bit sb, input bit hi, input logic [3:0] tg);
        if (!p) begin
            req0_valid = 1; req0_a = a; req0_b = b; req0_sa = sa; req0_sb = sb; req0_hi = hi; req0_tag = tg;
        end else begin
            req1_valid = 1; req1_a = a; req1_b = b; req1_sa = sa; req1_sb = sb; req1_hi = hi; req1_tag = tg;
        end
    endtask

    task automatic single(input bit p, input logic [31:0] a, input logic [31:0] b,
                          input bit sa, input bit sb, input bit hi, input logic [3:0] tg,
                          input logic [31:0] exp);
        drv(p, a, b, sa, sb, hi, tg);
        settle();
        chk("single_ready", p ? req1_ready : req0_ready, 1);
        tick();
        clr();
        settle();
        chk("single_inflight", inflight, 1);
        chk("single_dp_a", dp_a, a);
        tick();
        chk("single_not_yet", resp_valid, 0);
        tick();
        chk("single_valid", resp_valid, 1);
        chk("single_data", resp_data, exp);
        chk("single_id", resp_id, p);
        chk("single_tag", resp_tag, tg);
        tick();
        chk("single_drained", resp_valid, 0);
    endtask

    logic [31:0] rr_data [4] = '{32'd3, 32'd10, 32'd9, 32'd20};
    logic [3:0]  rr_tag  [4] = '{4'd0, 4'd9, 4'd2, 4'd11};

    initial begin
        clr();
        flush = 0;
        resp_ready = 1;
        settle();
        chk("rst_resp_valid", resp_valid, 0);
        chk("rst_inflight", inflight, 0);
        chk("rst_en_s2", dp_en_s2, 0);
        chk("rst_dp_a", dp_a, 0);
        tick();
        rst = 0;

        // single operations, signed/unsigned and both halves
        single(0, 32'hFFFFFFFF, 32'd2, 1, 1, 0, 4'd5, 32'hFFFFFFFE);
        single(0, 32'hFFFFFFFF, 32'd2, 1, 1, 1, 4'd5, 32'hFFFFFFFF);
        single(0, 32'hFFFFFFFF, 32'd2, 0, 0, 1, 4'd5, 32'h00000001);
        single(1, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 0, 1, 4'd6, 32'hFFFFFFFE);

        // round-robin with both ports requesting; pointer is 0 after the port-1 op
        for (int k = 0; k < 7; k++) begin
            clr();
            if (k < 4) begin
                drv(0, k + 1, 32'd3, 0, 0, 0, k);
                drv(1, k + 1, 32'd5, 0, 0, 0, 8 + k);
            end
            settle();
            if (k < 4) begin
                chk("rr_ready0", req0_ready, (k % 2 == 0));
                chk("rr_ready1", req1_ready, (k % 2 == 1));
            end
            if (k == 3 || k == 4) chk("rr_inflight", inflight, 3);
            if (k >= 3) begin
                chk("rr_valid", resp_valid, 1);
                chk("rr_id", resp_id, (k - 3) % 2);
                chk("rr_tag", resp_tag, rr_tag[k-3]);
                chk("rr_data", resp_data, rr_data[k-3]);
            end
            tick();
        end
        clr();
        settle();
        chk("rr_drained", resp_valid, 0);

        // backpressure: three ops fill the pipe while the consumer stalls
        resp_ready = 0;
        for (int i = 0; i < 3; i++) begin
            drv(0, 10 + i, 32'd7, 0, 0, 0, 1 + i);
            settle();
            chk("bp_fill_ready", req0_ready, 1);
            tick();
        end
        drv(0, 32'd99, 32'd1, 0, 0, 0, 4'd4);
        for (int i = 0; i < 5; i++) begin
            settle();
            chk("bp_inflight", inflight, 3);
            chk("bp_req_ready", req0_ready, 0);
            chk("bp_valid", resp_valid, 1);
            chk("bp_tag", resp_tag, 1);
            chk("bp_data", resp_data, 70);
            tick();
        end
        clr();
        resp_ready = 1;
        for (int i = 0; i < 3; i++) begin
            settle();
            chk("bp_rel_valid", resp_valid, 1);
            chk("bp_rel_tag", resp_tag, 1 + i);
            chk("bp_rel_data", resp_data, 70 + 7 * i);
            tick();
        end
        chk("bp_rel_empty", resp_valid, 0);
        chk("bp_rel_inflight", inflight, 0);

        // bubble collapse behind a stalled S3
        resp_ready = 0;
        drv(0, 32'hFFFFFFFF, 32'hFFFFFFFF, 1, 0, 1, 4'd9);
        settle();
        tick();
        clr();
        tick();
        tick();
        chk("bub_inflight1", inflight, 1);
        chk("bub_a_valid", resp_valid, 1);
        drv(0, 32'h80000000, 32'h80000000, 1, 1, 1, 4'd10);
        settle();
        chk("bub_accept", req0_ready, 1);
        tick();
        clr();
        settle();
        chk("bub_inflight2a", inflight, 2);
        chk("bub_en_s2", dp_en_s2, 1);
        tick();
        chk("bub_inflight2b", inflight, 2);
        chk("bub_en_s3_frozen", dp_en_s3, 0);
        chk("bub_en_s2_idle", dp_en_s2, 0);
        tick();
        chk("bub_inflight2c", inflight, 2);
        chk("bub_a_tag_stable", resp_tag, 9);
        resp_ready = 1;
        settle();
        chk("bub_a_data", resp_data, 32'hFFFFFFFF);
        chk("bub_en_s3_rel", dp_en_s3, 1);
        tick();
        chk("bub_b_valid", resp_valid, 1);
        chk("bub_b_tag", resp_tag, 10);
        chk("bub_b_data", resp_data, 32'h40000000);
        tick();
        chk("bub_empty", resp_valid, 0);

        // flush with three in flight and a live request
        for (int i = 0; i < 3; i++) begin
            drv(0, i + 1, 32'd1, 0, 0, 0, i);
            settle();
            chk("fl_fill_ready", req0_ready, 1);
            tick();
        end
        drv(0, 32'd5, 32'd5, 0, 0, 0, 4'd7);
        flush = 1;
        settle();
        chk("fl_req_ready", req0_ready, 0);
        chk("fl_inflight", inflight, 3);
        chk("fl_resp_valid", resp_valid, 1);
        chk("fl_resp_tag", resp_tag, 0);
        tick();
        flush = 0;
        clr();
        settle();
        chk("fl_after_inflight", inflight, 0);
        chk("fl_after_valid", resp_valid, 0);
        drv(0, 32'd1, 32'd1, 0, 0, 0, 4'd1);
        drv(1, 32'd2, 32'd2, 0, 0, 0, 4'd2);
        settle();
        chk("fl_rr_hold0", req0_ready, 0);
        chk("fl_rr_hold1", req1_ready, 1);
        tick();
        settle();
        chk("fl_rr_next0", req0_ready, 1);
        tick();
        clr();
        settle();
        chk("ar_pre_inflight", inflight, 2);

        // asynchronous reset between clock edges
        #2;
        rst = 1;
        #1;
        chk("ar_inflight", inflight, 0);
        chk("ar_valid", resp_valid, 0);
        chk("ar_dp_a", dp_a, 0);
        chk("ar_en_s2", dp_en_s2, 0);
        req0_valid = 1;
        #1;
        chk("ar_req_ready", req0_ready, 0);
        tick();
        rst = 0;
        clr();
        drv(0, 32'd6, 32'hFFFFFFFD, 1, 1, 0, 4'd3);
        drv(1, 32'd7, 32'd7, 0, 0, 0, 4'd4);
        settle();
        chk("ar_tie0", req0_ready, 1);
        chk("ar_tie1", req1_ready, 0);
        tick();
        clr();
        tick();
        chk("ar_lat_not_yet", resp_valid, 0);
        tick();
        chk("ar_lat_valid", resp_valid, 1);
        chk("ar_lat_id", resp_id, 0);
        chk("ar_lat_tag", resp_tag, 3);
        chk("ar_lat_data", resp_data, 32'hFFFFFFEE);
        tick();
        chk("ar_end_empty", resp_valid, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
